// File: rtl/core_wb_dmem_pkg.sv
// Shared definitions for the data-memory Wishbone slave:
// FSM state encodings, legal byte-lane selects, bus width.
package i2d_core_defines;

   localparam int WB_DW = 32;

   typedef enum logic [1:0] {
      DM_IDLE,
      DM_WAIT,
      DM_RESP,
      DM_ERR
   } dm_state_t;

   // Legal sel patterns: single bytes, aligned halves, full word.
   localparam int SEL_N = 7;
   localparam logic [4*SEL_N-1:0] SEL_LIST = {
      4'b0001, 4'b0010, 4'b0100, 4'b1000,
      4'b0011, 4'b1100, 4'b1111
   };

   function automatic logic sel_ok(input logic [3:0] s);
      logic ok;
      ok = 1'b0;
      for (int i = 0; i < SEL_N; i++) begin
         if (SEL_LIST[i*4 +: 4] == s) ok = 1'b1;
      end
      return ok;
   endfunction

endpackage

// File: rtl/core_wb_dmem_if.sv
// Wishbone B3 classic data-bus bundle between MAU and dmem.
// Ports: adr/dat/sel/we/cyc/stb request, dat_o/ack/err/rty reply.
interface core_wb_dmem_if;
   import i2d_core_defines::*;

   logic [31:0]      adr_i;
   logic [WB_DW-1:0] dat_i;
   logic [WB_DW-1:0] dat_o;
   logic [3:0]       sel_i;
   logic             we_i;
   logic             cyc_i;
   logic             stb_i;
   logic             ack_o;
   logic             err_o;
   logic             rty_o;

   modport master (
      output adr_i, dat_i, sel_i, we_i, cyc_i, stb_i,
      input  dat_o, ack_o, err_o, rty_o
   );

   modport slave (
      input  adr_i, dat_i, sel_i, we_i, cyc_i, stb_i,
      output dat_o, ack_o, err_o, rty_o
   );

endinterface

// File: rtl/core_wb_dmem_spram.sv
// Single-port synchronous RAM with byte write enables.
// Ports: clk, en, we[3:0], addr, din; dout registered on en.
module core_spram #(
   parameter int AW = 12,
   parameter int DW = 32
) (
   input  logic            clk,
   input  logic            en,
   input  logic [DW/8-1:0] we,
   input  logic [AW-1:0]   addr,
   input  logic [DW-1:0]   din,
   output logic [DW-1:0]   dout
);

   logic [DW-1:0] mem [2**AW];

   always_ff @(posedge clk) begin
      if (en) begin
         for (int i = 0; i < DW/8; i++) begin
            if (we[i]) mem[addr][i*8 +: 8] <= din[i*8 +: 8];
         end
         dout <= mem[addr];
      end
   end

endmodule

// File: rtl/core_wb_dmem.sv
// Wishbone B3 classic data-memory slave with wait states and err.
// Ports: clk, rst (sync, active low), bus (slave modport).
module core_wb_dmem
   import i2d_core_defines::*;
#(
   parameter int          AW          = 12,
   parameter int          WAIT_STATES = 1,
   parameter logic [31:0] BASE        = 32'h0000_0000
) (
   input  logic           clk,
   input  logic           rst,
   core_wb_dmem_if.slave  bus
);

   localparam int WS_M1 = (WAIT_STATES > 0) ? WAIT_STATES - 1 : 0;
   localparam logic [3:0] WS_LOAD = 4'(WS_M1);

   dm_state_t        state;
   dm_state_t        nxt;
   logic [3:0]       cnt;
   logic             load;

   logic [AW-1:0]    lat_word;
   logic [WB_DW-1:0] lat_dat;
   logic [3:0]       lat_sel;
   logic             lat_we;

   logic [31:0]      off;
   logic             in_rng;
   logic             legal;
   logic             req;
   logic [AW-1:0]    word_live;

   logic             ram_en;
   logic [3:0]       ram_we;
   logic [AW-1:0]    ram_addr;
   logic [WB_DW-1:0] ram_dout;

   // Subtracting BASE first lets one shift test both range ends.
   assign off       = bus.adr_i - BASE;
   assign in_rng    = (off >> (AW + 2)) == 32'd0;
   assign legal     = in_rng && (off[1:0] == 2'b00) && sel_ok(bus.sel_i);
   assign req       = bus.cyc_i & bus.stb_i;
   assign word_live = off[AW+1:2];

   always_ff @(posedge clk) begin
      if (!rst) begin
         state    <= DM_IDLE;
         cnt      <= '0;
         lat_word <= '0;
         lat_dat  <= '0;
         lat_sel  <= '0;
         lat_we   <= 1'b0;
      end else begin
         state <= nxt;
         if (state == DM_IDLE && req && legal) begin
            lat_word <= word_live;
            lat_dat  <= bus.dat_i;
            lat_sel  <= bus.sel_i;
            lat_we   <= bus.we_i;
         end
         if (load) begin
            cnt <= WS_LOAD;
         end else if (state == DM_WAIT && cnt != 4'd0) begin
            cnt <= cnt - 4'd1;
         end
      end
   end

   always_comb begin
      nxt  = state;
      load = 1'b0;
      unique case (state)
         DM_IDLE: begin
            if (req) begin
               if (!legal) begin
                  nxt = DM_ERR;
               end else if (WAIT_STATES == 0) begin
                  nxt = DM_RESP;
               end else begin
                  nxt  = DM_WAIT;
                  load = 1'b1;
               end
            end
         end
         DM_WAIT: begin
            if (!req) nxt = DM_IDLE;
            else if (cnt == 4'd0) nxt = DM_RESP;
         end
         DM_RESP: nxt = DM_IDLE;
         DM_ERR:  nxt = DM_IDLE;
         default: nxt = DM_IDLE;
      endcase
   end

   // The RAM read is launched one cycle ahead of RESP so its
   // registered output is ready with ack; the write lands at the
   // edge that closes RESP and is blocked if reset is sampled there.
   always_comb begin
      ram_en   = 1'b0;
      ram_we   = '0;
      ram_addr = lat_word;
      unique case (state)
         DM_IDLE: begin
            if (WAIT_STATES == 0 && req && legal) begin
               ram_en   = 1'b1;
               ram_addr = word_live;
            end
         end
         DM_WAIT: begin
            if (req && cnt == 4'd0) ram_en = 1'b1;
         end
         DM_RESP: begin
            if (lat_we) begin
               ram_en = 1'b1;
               ram_we = lat_sel & {4{rst}};
            end
         end
         default: ;
      endcase
   end

   core_spram #(
      .AW (AW),
      .DW (WB_DW)
   ) u_ram (
      .clk  (clk),
      .en   (ram_en),
      .we   (ram_we),
      .addr (ram_addr),
      .din  (lat_dat),
      .dout (ram_dout)
   );

   assign bus.ack_o = (state == DM_RESP);
   assign bus.err_o = (state == DM_ERR);
   assign bus.dat_o = bus.ack_o ? ram_dout : '0;
   assign bus.rty_o = 1'b0;

endmodule

// File: tb/tb_core_wb_dmem.sv
// Directed bench for core_wb_dmem at WAIT_STATES 0, 1 and 3.
// Table of single transfers plus abort/back-to-back/reset sequences.
module tb_core_wb_dmem;
   import i2d_core_defines::*;

   logic        clk = 1'b0;
   logic        rst = 1'b0;

   logic [31:0] adr  [3];
   logic [31:0] wdat [3];
   logic [3:0]  sel  [3];
   logic        we   [3];
   logic        cyc  [3];
   logic        stb  [3];
   logic [31:0] rdat [3];
   logic        ack  [3];
   logic        err  [3];
   logic        rty  [3];

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   core_wb_dmem_if bus0 ();
   core_wb_dmem_if bus1 ();
   core_wb_dmem_if bus3 ();

   assign bus0.adr_i = adr[0];
   assign bus0.dat_i = wdat[0];
   assign bus0.sel_i = sel[0];
   assign bus0.we_i  = we[0];
   assign bus0.cyc_i = cyc[0];
   assign bus0.stb_i = stb[0];
   assign rdat[0]    = bus0.dat_o;
   assign ack[0]     = bus0.ack_o;
   assign err[0]     = bus0.err_o;
   assign rty[0]     = bus0.rty_o;

   assign bus1.adr_i = adr[1];
   assign bus1.dat_i = wdat[1];
   assign bus1.sel_i = sel[1];
   assign bus1.we_i  = we[1];
   assign bus1.cyc_i = cyc[1];
   assign bus1.stb_i = stb[1];
   assign rdat[1]    = bus1.dat_o;
   assign ack[1]     = bus1.ack_o;
   assign err[1]     = bus1.err_o;
   assign rty[1]     = bus1.rty_o;

   assign bus3.adr_i = adr[2];
   assign bus3.dat_i = wdat[2];
   assign bus3.sel_i = sel[2];
   assign bus3.we_i  = we[2];
   assign bus3.cyc_i = cyc[2];
   assign bus3.stb_i = stb[2];
   assign rdat[2]    = bus3.dat_o;
   assign ack[2]     = bus3.ack_o;
   assign err[2]     = bus3.err_o;
   assign rty[2]     = bus3.rty_o;

   core_wb_dmem #(.AW(12), .WAIT_STATES(0)) u0 (
      .clk (clk), .rst (rst), .bus (bus0.slave));
   core_wb_dmem #(.AW(12), .WAIT_STATES(1)) u1 (
      .clk (clk), .rst (rst), .bus (bus1.slave));
   core_wb_dmem #(.AW(12), .WAIT_STATES(3)) u2 (
      .clk (clk), .rst (rst), .bus (bus3.slave));

   typedef struct {
      logic        w;
      logic [31:0] a;
      logic [31:0] d;
      logic [3:0]  s;
      logic        e;
      logic        cd;
      logic [31:0] x;
      int          lat;
   } vec_t;

   vec_t vq[$];

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual %h required %h", name, act, exp);
      end
   endtask

   task automatic add(input logic w, input logic [31:0] a,
                      input logic [31:0] d, input logic [3:0] s,
                      input logic e, input logic cd,
                      input logic [31:0] x, input int lat);
      vec_t v;
      v = '{w: w, a: a, d: d, s: s, e: e, cd: cd, x: x, lat: lat};
      vq.push_back(v);
   endtask

   // One transfer; lat counts cycles of stb high up to and
   // including the termination cycle, 0 if it never terminates.
   task automatic txn(input int d, input logic w, input logic [31:0] a,
                      input logic [31:0] wd, input logic [3:0] s,
                      output logic [31:0] rd, output int lat,
                      output logic e, output logic extra);
      lat = 0;
      rd = '0;
      e = 1'b0;
      extra = 1'b0;
      @(posedge clk); #1;
      adr[d] = a; wdat[d] = wd; sel[d] = s; we[d] = w;
      cyc[d] = 1'b1; stb[d] = 1'b1;
      for (int i = 1; i <= 30 && lat == 0; i++) begin
         @(negedge clk);
         if (ack[d] || err[d]) begin
            lat = i;
            rd = rdat[d];
            e = err[d];
         end
      end
      @(posedge clk); #1;
      cyc[d] = 1'b0; stb[d] = 1'b0;
      @(negedge clk);
      if (ack[d] || err[d]) extra = 1'b1;
   endtask

   task automatic rd_chk(input int d, input string name,
                         input logic [31:0] a, input logic [31:0] x,
                         input int lat_x);
      logic [31:0] rd;
      int lat;
      logic e, extra;
      txn(d, 1'b0, a, 32'h0, 4'hF, rd, lat, e, extra);
      chk({name, "_lat"}, 32'(lat), 32'(lat_x));
      chk({name, "_dat"}, rd, x);
      chk({name, "_err"}, {31'd0, e | extra}, 32'd0);
   endtask

   task automatic wr_ok(input int d, input string name,
                        input logic [31:0] a, input logic [31:0] v,
                        input int lat_x);
      logic [31:0] rd;
      int lat;
      logic e, extra;
      txn(d, 1'b1, a, v, 4'hF, rd, lat, e, extra);
      chk({name, "_lat"}, 32'(lat), 32'(lat_x));
      chk({name, "_err"}, {31'd0, e | extra}, 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog actual timeout required finish");
      $fatal(1);
   end

   initial begin
      logic [31:0] rd;
      int lat, nack, bad, seen;
      logic e, extra;
      logic [31:0] pre [4];

      for (int d = 0; d < 3; d++) begin
         adr[d] = '0; wdat[d] = '0; sel[d] = '0;
         we[d] = 1'b0; cyc[d] = 1'b0; stb[d] = 1'b0;
      end
      rst = 1'b0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b1;
      @(negedge clk);
      for (int d = 0; d < 3; d++) begin
         chk($sformatf("rst_ack%0d", d), {31'd0, ack[d]}, 32'd0);
         chk($sformatf("rst_err%0d", d), {31'd0, err[d]}, 32'd0);
         chk($sformatf("rst_dat%0d", d), rdat[d], 32'd0);
         chk($sformatf("rst_rty%0d", d), {31'd0, rty[d]}, 32'd0);
      end

      // WAIT_STATES=1 transfers: ok -> 3 cycles, error -> 2.
      add(1, 32'h10,   32'hDEADBEEF, 4'hF, 0, 0, 32'h0,        3);
      add(0, 32'h10,   32'h0,        4'hF, 0, 1, 32'hDEADBEEF, 3);
      add(1, 32'h20,   32'h11223344, 4'hF, 0, 0, 32'h0,        3);
      add(1, 32'h20,   32'h00AA0000, 4'h4, 0, 0, 32'h0,        3);
      add(0, 32'h20,   32'h0,        4'hF, 0, 1, 32'h11AA3344, 3);
      add(1, 32'h20,   32'h0000BEEF, 4'h3, 0, 0, 32'h0,        3);
      add(0, 32'h20,   32'h0,        4'hF, 0, 1, 32'h11AABEEF, 3);
      add(1, 32'h00,   32'h01020304, 4'hF, 0, 0, 32'h0,        3);
      add(1, 32'h22,   32'hFFFFFFFF, 4'hF, 1, 1, 32'h0,        2);
      add(1, 32'h4000, 32'hFFFFFFFF, 4'hF, 1, 1, 32'h0,        2);
      add(1, 32'h20,   32'hFFFFFFFF, 4'h5, 1, 1, 32'h0,        2);
      add(0, 32'h20,   32'h0,        4'h0, 1, 1, 32'h0,        2);
      add(0, 32'h20,   32'h0,        4'hF, 0, 1, 32'h11AABEEF, 3);
      add(0, 32'h00,   32'h0,        4'hF, 0, 1, 32'h01020304, 3);
      add(1, 32'h3FFC, 32'h00000000, 4'hF, 0, 0, 32'h0,        3);
      add(1, 32'h3FFC, 32'hCAFEF00D, 4'h8, 0, 0, 32'h0,        3);
      add(1, 32'h3FFC, 32'h0000F00D, 4'h2, 0, 0, 32'h0,        3);
      add(0, 32'h3FFC, 32'h0,        4'hF, 0, 1, 32'hCA00F000, 3);

      foreach (vq[i]) begin
         txn(1, vq[i].w, vq[i].a, vq[i].d, vq[i].s, rd, lat, e, extra);
         chk($sformatf("v%0d_lat", i), 32'(lat), 32'(vq[i].lat));
         chk($sformatf("v%0d_err", i), {31'd0, e}, {31'd0, vq[i].e});
         chk($sformatf("v%0d_once", i), {31'd0, extra}, 32'd0);
         if (vq[i].cd) chk($sformatf("v%0d_dat", i), rd, vq[i].x);
      end

      // Reset sampled at the edge closing RESP blocks the write.
      @(posedge clk); #1;
      adr[1] = 32'h10; wdat[1] = 32'h0; sel[1] = 4'hF; we[1] = 1'b1;
      cyc[1] = 1'b1; stb[1] = 1'b1;
      @(posedge clk); #1;
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      chk("rresp_ack", {31'd0, ack[1]}, 32'd1);
      @(posedge clk); #1;
      rst = 1'b1; cyc[1] = 1'b0; stb[1] = 1'b0;
      @(negedge clk);
      chk("rresp_ack_after", {31'd0, ack[1]}, 32'd0);
      rd_chk(1, "rresp_rd", 32'h10, 32'hDEADBEEF, 3);

      // Abort on WAIT_STATES=3: stb drops in the 2nd WAIT cycle.
      wr_ok(2, "ab_pre", 32'h30, 32'h11111111, 5);
      @(posedge clk); #1;
      adr[2] = 32'h30; wdat[2] = 32'h5A5A5A5A; sel[2] = 4'hF;
      we[2] = 1'b1; cyc[2] = 1'b1; stb[2] = 1'b1;
      @(posedge clk); #1;
      @(posedge clk); #1;
      stb[2] = 1'b0;
      seen = 0;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         if (ack[2] || err[2]) seen++;
      end
      cyc[2] = 1'b0;
      chk("ab_term", 32'(seen), 32'd0);
      rd_chk(2, "ab_rd", 32'h30, 32'h11111111, 5);

      // Back-to-back reads on WAIT_STATES=0 with stb held high.
      for (int i = 0; i < 4; i++) begin
         pre[i] = 32'hA5000000 + 32'(i * 17);
         wr_ok(0, $sformatf("bb_pre%0d", i), 32'(i * 4), pre[i], 2);
      end
      @(posedge clk); #1;
      adr[0] = 32'h0; sel[0] = 4'hF; we[0] = 1'b0;
      cyc[0] = 1'b1; stb[0] = 1'b1;
      nack = 0;
      bad = 0;
      for (int c = 1; c <= 12; c++) begin
         @(negedge clk);
         if (err[0]) bad++;
         if (ack[0]) begin
            chk($sformatf("bb_dat%0d", nack), rdat[0], pre[nack & 3]);
            chk($sformatf("bb_cyc%0d", nack), 32'(c), 32'(2 * (nack + 1)));
            nack++;
            @(posedge clk); #1;
            if (nack >= 4) begin
               cyc[0] = 1'b0; stb[0] = 1'b0;
            end else begin
               adr[0] = 32'(nack * 4);
            end
         end else if (rdat[0] !== 32'h0) begin
            bad++;
         end
      end
      cyc[0] = 1'b0; stb[0] = 1'b0;
      chk("bb_nack", 32'(nack), 32'd4);
      chk("bb_idle", 32'(bad), 32'd0);

      // Reset during WAIT of a write on WAIT_STATES=3.
      wr_ok(2, "rw_pre", 32'h34, 32'h77777777, 5);
      @(posedge clk); #1;
      adr[2] = 32'h34; wdat[2] = 32'h12345678; sel[2] = 4'hF;
      we[2] = 1'b1; cyc[2] = 1'b1; stb[2] = 1'b1;
      @(posedge clk); #1;
      @(posedge clk); #1;
      rst = 1'b0;
      @(posedge clk); #1;
      rst = 1'b1; cyc[2] = 1'b0; stb[2] = 1'b0;
      @(negedge clk);
      chk("rw_ack", {31'd0, ack[2]}, 32'd0);
      chk("rw_err", {31'd0, err[2]}, 32'd0);
      chk("rw_state", 32'(u2.state), 32'(DM_IDLE));
      seen = 0;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         if (ack[2] || err[2]) seen++;
      end
      chk("rw_quiet", 32'(seen), 32'd0);
      rd_chk(2, "rw_rd", 32'h34, 32'h77777777, 5);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
